// File: rtl/tick_scheduler.sv
// Shared prescaler plus four programmable tick/square-wave channels for the XO game's slow timing.
// Define TICK_SCHED_SQUARE_EN to build the per-channel square-wave toggle flops; otherwise sq is tied low.
module tick_scheduler #(
  parameter int PRESCALE = 100000,
  parameter int PRE_SIZE = 17,
  parameter int DIV_SIZE = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_chan,
  input  logic [DIV_SIZE-1:0] cfg_div,
  output logic                base_tick,
  output logic [3:0]          tick,
  output logic [3:0]          sq
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  localparam logic [PRE_SIZE-1:0] PCNT_LAST = PRE_SIZE'(PRESCALE - 1);
  localparam logic [DIV_SIZE-1:0] DIV_ONE   = DIV_SIZE'(1);

  // ------------------------------------------------------------------
  // Prescaler
  // ------------------------------------------------------------------
  logic [PRE_SIZE-1:0] pcnt_q, pcnt_d;
  logic                base_tick_q, base_tick_d;

  always_comb begin
    pcnt_d      = pcnt_q;
    base_tick_d = 1'b0;
    if (enable) begin
      if (pcnt_q == PCNT_LAST) begin
        pcnt_d      = '0;
        base_tick_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q      <= '0;
      base_tick_q <= 1'b0;
    end else begin
      pcnt_q      <= pcnt_d;
      base_tick_q <= base_tick_d;
    end
  end

  assign base_tick = base_tick_q;

  // ------------------------------------------------------------------
  // Configuration handshake: IDLE accepts, LOAD writes the channel
  // ------------------------------------------------------------------
  logic [0:0]          state_q, state_d;
  logic [1:0]          chan_q, chan_d;
  logic [DIV_SIZE-1:0] ldiv_q, ldiv_d;

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    ldiv_d  = ldiv_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          chan_d  = cfg_chan;
          ldiv_d  = cfg_div;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      chan_q  <= 2'd0;
      ldiv_q  <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      ldiv_q  <= ldiv_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);

  // ------------------------------------------------------------------
  // Channels
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_chan
    logic [DIV_SIZE-1:0] div_q, div_d;
    logic [DIV_SIZE-1:0] cnt_q, cnt_d;
    logic                tick_q, tick_d;
    logic                load_hit;
    logic                step;
    logic                wrap;

    // A LOAD aimed at this channel takes priority over a coincident base tick.
    assign load_hit = (state_q == ST_LOAD) && (chan_q == 2'(gi));
    assign step     = base_tick_q && (div_q != '0);
    assign wrap     = (cnt_q == (div_q - DIV_ONE));

    always_comb begin
      div_d  = div_q;
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (load_hit) begin
        div_d = ldiv_q;
        cnt_d = '0;
      end else if (step) begin
        if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        div_q  <= '0;
        cnt_q  <= '0;
        tick_q <= 1'b0;
      end else begin
        div_q  <= div_d;
        cnt_q  <= cnt_d;
        tick_q <= tick_d;
      end
    end

    assign tick[gi] = tick_q;

`ifdef TICK_SCHED_SQUARE_EN
    logic sq_q, sq_d;

    always_comb begin
      sq_d = sq_q;
      if (load_hit) begin
        sq_d = 1'b0;
      end else if (step && wrap) begin
        sq_d = ~sq_q;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sq_q <= 1'b0;
      end else begin
        sq_q <= sq_d;
      end
    end

    assign sq[gi] = sq_q;
`else
    assign sq[gi] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Randomised and directed bench for tick_scheduler against an event-counting reference model.
module tb_tick_scheduler;

  localparam int P  = 4;
  localparam int DW = 4;
`ifdef TICK_SCHED_SQUARE_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          enable    = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [1:0]    cfg_chan  = 2'd0;
  logic [DW-1:0] cfg_div   = '0;
  logic          cfg_ready;
  logic          base_tick;
  logic [3:0]    tick;
  logic [3:0]    sq;

  tick_scheduler #(.PRESCALE(P), .PRE_SIZE(2), .DIV_SIZE(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .base_tick (base_tick),
    .tick      (tick),
    .sq        (sq)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_no = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc_no, act, exp);
    end
  endtask

  // Reference model: counts enabled clocks and qualifying base ticks since load.
  int       m_en_cnt;
  bit       m_bt;
  bit       m_ready;
  bit       m_pend;
  int       m_pchan;
  int       m_pdiv;
  int       m_div[4];
  int       m_n[4];
  bit [3:0] m_tick;
  bit [3:0] m_sq;

  task automatic model_reset();
    m_en_cnt = 0;
    m_bt     = 1'b0;
    m_ready  = 1'b1;
    m_pend   = 1'b0;
    m_pchan  = 0;
    m_pdiv   = 0;
    m_tick   = '0;
    m_sq     = '0;
    for (int k = 0; k < 4; k++) begin
      m_div[k] = 0;
      m_n[k]   = 0;
    end
  endtask

  task automatic model_step();
    if (!reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 4; k++) begin
      if (m_pend && m_pchan == k) begin
        m_div[k]  = m_pdiv;
        m_n[k]    = 0;
        m_tick[k] = 1'b0;
        m_sq[k]   = 1'b0;
      end else if (m_bt && m_div[k] != 0) begin
        m_n[k]++;
        m_tick[k] = (m_n[k] % m_div[k]) == 0;
        m_sq[k]   = SQ_EN && (((m_n[k] / m_div[k]) % 2) == 1);
      end else begin
        m_tick[k] = 1'b0;
      end
    end
    if (enable) begin
      m_en_cnt++;
      m_bt = (m_en_cnt % P) == 0;
    end else begin
      m_bt = 1'b0;
    end
    if (m_ready && cfg_valid) begin
      m_pend  = 1'b1;
      m_pchan = int'(cfg_chan);
      m_pdiv  = int'(cfg_div);
      m_ready = 1'b0;
    end else begin
      m_pend  = 1'b0;
      m_ready = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("base_tick", int'(base_tick), int'(m_bt));
      chk("tick", int'(tick), int'(m_tick));
      chk("sq", int'(sq), int'(m_sq));
      chk("cfg_ready", int'(cfg_ready), int'(m_ready));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    cyc_no++;
    @(negedge clk);
    #2;
  endtask

  task automatic wait_tick(input int k, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (tick[k]) begin
        at = cyc_no;
        break;
      end
    end
    if (at < 0) chk($sformatf("tick%0d_timeout", k), 0, 1);
  endtask

  task automatic send(input int ch, input int dv);
    cfg_valid = 1'b1;
    cfg_chan  = 2'(ch);
    cfg_div   = DW'(dv);
    cyc();
    cfg_valid = 1'b0;
    chk("ready_in_load", int'(cfg_ready), 0);
    cyc();
    chk("ready_after_load", int'(cfg_ready), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, ld, cnt;
    bit s0, s1, found;
    int bdiv[4];
    bdiv[0] = 3; bdiv[1] = 9; bdiv[2] = 2; bdiv[3] = 4;

    #1 reset = 1'b0;
    model_reset();
    #1 chk_on = 1'b1;
    enable = 1'b1;
    repeat (3) cyc();
    reset  = 1'b1;
    cyc_no = 0;

    // First base tick lands in cycle PRESCALE after release.
    repeat (3) begin
      cyc();
      chk("bt_early", int'(base_tick), 0);
    end
    cyc();
    chk("bt_first", int'(base_tick), 1);
    chk("tick_idle", int'(tick), 0);
    chk("ready_idle", int'(cfg_ready), 1);
    repeat (3) cyc();
    cyc();
    chk("bt_second", int'(base_tick), 1);

    // Channel 0 at div 3: tick period 12, square wave toggles per tick.
    send(0, 3);
    wait_tick(0, 40, t0);
    s0 = sq[0];
    wait_tick(0, 40, t1);
    s1 = sq[0];
    chk("ch0_period", t1 - t0, 12);
    chk("sq0_toggle", int'(s0 ^ s1), int'(SQ_EN));

    // LOAD of ch1 coincides with a base tick.
    cnt = 0;
    while (!base_tick && cnt < 20) begin
      cyc();
      cnt++;
    end
    repeat (P - 1) cyc();
    cfg_valid = 1'b1;
    cfg_chan  = 2'd1;
    cfg_div   = DW'(2);
    cyc();
    cfg_valid = 1'b0;
    chk("bt_on_load", int'(base_tick), 1);
    chk("ready_on_load", int'(cfg_ready), 0);
    ld = cyc_no;
    wait_tick(1, 40, t0);
    chk("ch1_first", t0 - ld, 9);
    wait_tick(1, 40, t1);
    chk("ch1_period", t1 - t0, 8);
    wait_tick(0, 40, t0);
    wait_tick(0, 40, t1);
    chk("ch0_period_after_load", t1 - t0, 12);

    // Back-to-back requests: only ch0 and ch2 are accepted.
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1;
      cfg_chan  = 2'(i);
      cfg_div   = DW'(bdiv[i]);
      chk("burst_ready", int'(cfg_ready), (i % 2 == 0) ? 1 : 0);
      cyc();
    end
    cfg_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 48; i++) begin
      cyc();
      if (tick[3]) cnt++;
    end
    chk("ch3_rejected", cnt, 0);
    wait_tick(1, 40, t0);
    wait_tick(1, 40, t1);
    chk("ch1_kept", t1 - t0, 8);

    // Pause the prescaler for 10 cycles.
    wait_tick(0, 40, t0);
    repeat (5) cyc();
    enable = 1'b0;
    cnt = 0;
    repeat (10) begin
      cyc();
      if (base_tick || tick[0]) cnt++;
    end
    enable = 1'b1;
    chk("paused_quiet", cnt, 0);
    wait_tick(0, 60, t2);
    chk("ch0_after_pause", t2 - t0, 22);

    // Async reset while sq[0] is high and a LOAD is pending.
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sq[0] == SQ_EN) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk("sq0_high_seen", int'(found), 1);
    cfg_valid = 1'b1;
    cfg_chan  = 2'd2;
    cfg_div   = DW'(5);
    cyc();
    cfg_valid = 1'b0;
    #1 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_tick", int'(tick), 0);
    chk("rst_sq", int'(sq), 0);
    chk("rst_bt", int'(base_tick), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    repeat (2) cyc();
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (tick != 4'b0) cnt++;
    end
    chk("post_reset_idle", cnt, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_chan  = 2'($urandom);
      cfg_div   = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom_range(0, 4));
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        model_reset();
      end else begin
        reset = 1'b1;
      end
      cyc();
    end
    reset = 1'b1;
    cfg_valid = 1'b0;
    cyc();

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
